// File: rtl/hour_counter_12h_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hour_counter_12h_pkg
// Description : Shared BCD width, clamp-hour constants and hour validity test
//               for the alarm-clock time chain stages.
// Revision    : 1.0 - initial release
// ============================================================================
package hour_counter_12h_pkg;

   localparam int unsigned        c_BCD_W       = 4;
   localparam logic               c_CLAMP_TENS  = 1'b1;
   localparam logic [c_BCD_W-1:0] c_CLAMP_UNITS = 4'd2;

   // True when tens/units form a legal 12-hour value (01..09, 10, 11, 12).
   function automatic logic hour_is_valid(input logic               tens,
                                          input logic [c_BCD_W-1:0] units);
      logic ok;
      ok = (units <= 4'd9);
      if (!tens && (units == 4'd0)) ok = 1'b0;
      if (tens && (units > 4'd2))   ok = 1'b0;
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hour_counter_12h_btn_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : btn_sync_edge
// Description : SYNC_STAGES-deep synchroniser for an asynchronous button
//               level followed by a one-cycle rising-edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic Clk,
   input  logic Clr,
   input  logic i_btn,
   output logic o_pulse
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   // Shift the raw level through the synchroniser and remember the last
   // synchronised value; reset to 0 so releasing Clr never looks like a press.
   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/hour_counter_12h.sv
`default_nettype none
// ============================================================================
// Module      : hour_counter_12h
// Description : BCD hours stage (1..12) advanced by minute ticks or, in SET
//               mode, by synchronised button presses. Pulses PM_TOGGLE on the
//               11->12 step and supports clamped parallel load.
// Revision    : 1.0 - initial release
// ============================================================================
module hour_counter_12h
   import hour_counter_12h_pkg::*;
#(
   parameter logic               RESET_TENS  = 1'b1,
   parameter logic [c_BCD_W-1:0] RESET_UNITS = 4'd2,
   parameter int                 SYNC_STAGES = 2
) (
   input  logic               Clk,
   input  logic               Clr,
   input  logic               Enable,
   input  logic               LD,
   input  logic               IN_TENS,
   input  logic [c_BCD_W-1:0] IN_UNITS,
   input  logic               Tick,
   input  logic               SET,
   input  logic               INC_BTN,
   output logic               HR_TENS,
   output logic [c_BCD_W-1:0] HR_UNITS,
   output logic               PM_TOGGLE
);

   logic               w_inc_pulse;
   logic               w_adv;
   logic               w_load_ok;
   logic               r_tens;
   logic [c_BCD_W-1:0] r_units;
   logic               r_pm;

   // The synchroniser runs regardless of Enable, so presses while disabled
   // are simply consumed and lost.
   btn_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_btn_sync_edge (
      .Clk     (Clk),
      .Clr     (Clr),
      .i_btn   (INC_BTN),
      .o_pulse (w_inc_pulse)
   );

   assign w_adv     = SET ? w_inc_pulse : Tick;
   assign w_load_ok = hour_is_valid(IN_TENS, IN_UNITS);

   // Hour register: load beats advance (the advance is dropped), advance
   // walks 12,1..11,12, and PM_TOGGLE marks only the counted 11->12 step.
   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         r_tens  <= RESET_TENS;
         r_units <= RESET_UNITS;
         r_pm    <= 1'b0;
      end else begin
         r_pm <= 1'b0;
         if (Enable && LD) begin
            if (w_load_ok) begin
               r_tens  <= IN_TENS;
               r_units <= IN_UNITS;
            end else begin
               r_tens  <= c_CLAMP_TENS;
               r_units <= c_CLAMP_UNITS;
            end
         end else if (Enable && w_adv) begin
            if (r_tens && (r_units == 4'd2)) begin
               r_tens  <= 1'b0;
               r_units <= 4'd1;
            end else if (r_units == 4'd9) begin
               r_tens  <= 1'b1;
               r_units <= 4'd0;
            end else begin
               r_units <= r_units + 4'd1;
            end
            r_pm <= r_tens && (r_units == 4'd1);
         end
      end
   end

   assign HR_TENS   = r_tens;
   assign HR_UNITS  = r_units;
   assign PM_TOGGLE = r_pm;

endmodule
`default_nettype wire

// File: doc/hour_counter_12h.md
Name: hour_counter_12h

Overview:
BCD hours stage of the alarm-clock time chain. Counts 1..12 in BCD on minute-rollover ticks, or on debounced SET-mode button presses. Emits a one-cycle PM_TOGGLE pulse on every 11->12 transition. PM_TOGGLE drives the Up/Enable of the downstream 1-bit AM/PM counter. Supports parallel load with range clamping, for time/alarm setting.

Parameters:
RESET_TENS, 1, tens digit after reset (reset hour is 12).
RESET_UNITS, 2, units digit after reset.
SYNC_STAGES, 2, flops in the INC_BTN synchroniser (minimum 2).

Ports:
Clk  input  1  system clock, all state on posedge.
Clr  input  1  asynchronous, active-low reset; clears the block whenever low.
Enable  input  1  global advance/load qualifier.
LD  input  1  parallel load request (active high).
IN_TENS  input  1  load value, tens digit.
IN_UNITS  input  4  load value, units digit (BCD).
Tick  input  1  one-cycle pulse from the minutes stage on 59->00.
SET  input  1  set mode; when high, Tick is ignored and INC_BTN advances the hour.
INC_BTN  input  1  asynchronous push-button level, already debounced.
HR_TENS  output  1  current hour, tens digit.
HR_UNITS  output  4  current hour, units digit (BCD).
PM_TOGGLE  output  1  registered one-cycle pulse on the 11->12 step.

Behaviour:
- Reset (Clr low, asynchronous):
  - HR_TENS=RESET_TENS, HR_UNITS=RESET_UNITS, PM_TOGGLE=0.
  - Synchroniser and edge-detect flops all 0, so no spurious press is seen on release.
- Button path: INC_BTN passes through SYNC_STAGES flops. inc_pulse = rising edge of the synchronised level, one cycle wide. Latency from INC_BTN rise to inc_pulse = SYNC_STAGES cycles.
- Advance event: adv = SET ? inc_pulse : Tick.
- Priority at each posedge Clk (Clr high):
  1. LD & Enable -> load.
  2. adv & Enable -> increment.
  3. Otherwise hold.
  - LD wins over a simultaneous adv; that adv is dropped, not deferred.
- Increment sequence, one step per adv: 12 -> 1 -> 2 -> ... -> 9 -> 10 -> 11 -> 12.
  - Units digit 9 -> 0 sets tens to 1.
  - 12 -> 1 sets tens=0, units=1.
  - Never produces 0 or 13..19.
- PM_TOGGLE: set to 1 on the same edge the count goes 11->12, and cleared on the next edge. It goes high exactly one cycle after the adv cycle and lasts one cycle. It is 0 in every other case, including loads.
- Load rules:
  - A valid hour (10/11/12, or 01..09) loads as-is.
  - An invalid value (00, units>9, or tens=1 with units>2) loads 12.
  - A load never pulses PM_TOGGLE, even when the loaded value is 12.
- Enable low: count and PM_TOGGLE generation are frozen. The synchroniser keeps running, so a press while disabled is lost.
- SET toggling mid-press: only the adv source changes; no pending state is carried.
- Clr asserted mid-pulse: PM_TOGGLE drops immediately.
- Outputs are registered only; no combinational input->output path.

Decomposition:
- Shared package/header: BCD digit width (4) and the clamp hour constants (tens=1, units=2). The minutes/seconds stages reuse them.
- One natural sub-module: btn_sync_edge (SYNC_STAGES-deep synchroniser plus rising-edge detector, Clk/Clr). It is reused by the minutes set logic.

Test Plan:
- Clr low then high -> HR=1/2, PM_TOGGLE=0. Clr low during a PM_TOGGLE pulse -> pulse clears asynchronously.
- Enable=1, SET=0, 12 Tick pulses from 12 -> sequence 1,2,...,11,12. PM_TOGGLE high for exactly one cycle, one cycle after the 11->12 tick.
- LD with (1,5), (0,0), (0,10) -> HR loads 12 each time, PM_TOGGLE stays 0. LD with (0,7) -> HR=07.
- LD=1 and Tick=1 in the same cycle from 11, load value 03 -> HR=03, no PM_TOGGLE.
- SET=1, hold INC_BTN high 10 cycles from 09 -> HR=10 only after SYNC_STAGES cycles, single step. Tick pulses during SET -> no change.
- Enable=0 with Tick and LD pulses -> HR and PM_TOGGLE unchanged. Re-enable, Tick from 11 -> 12 with PM_TOGGLE pulse.
